debug_slave_sysclk_queue: RTL and testbench
===========================================

# debug_slave_sysclk_queue

Parametrised system-clock side of the CPU JTAG debug slave. It synchronises the update-IR and exit1-DR strobes that arrive from the TCK domain, latches the instruction register and the data shift register, and queues each completed DR scan as a command. Commands are presented to the CPU debug core through a valid/ready handshake with one-hot take_action/take_no_action pulses per instruction code. It replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk decoder. Commands now queue instead of being lost when the core is busy, and overflow is reported.

## Interface
Parameters:
- SR_WIDTH, 38, width of the DR shift register snapshot and of jdo/cmd_jdo (≥2)
- IR_WIDTH, 2, instruction register width; NUM_IR = 2**IR_WIDTH action channels
- SYNC_STAGES, 2, synchroniser flops per TCK-domain strobe (≥2)
- FIFO_DEPTH, 4, command queue depth (power of two, ≥2)

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vs_uir  in  1  update-IR level from the TCK domain; asynchronous to clk
- vs_e1dr  in  1  exit1-DR level from the TCK domain; asynchronous to clk
- ir_in  in  IR_WIDTH  instruction register; stable while vs_uir is synchronised
- sr  in  SR_WIDTH  DR shift register; stable while vs_e1dr is synchronised
- cmd_ready  in  1  core accepts the head command
- clr_overflow  in  1  clears cmd_overflow
- cmd_valid  out  1  queue non-empty
- cmd_ir  out  IR_WIDTH  head command instruction
- cmd_jdo  out  SR_WIDTH  head command data
- cmd_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- cmd_overflow  out  1  sticky: a capture was dropped
- ir_latched  out  IR_WIDTH  last IR latched on update-IR
- jdo  out  SR_WIDTH  last captured sr, regardless of queue state
- take_action  out  NUM_IR  one-cycle pulse, one-hot, on command pop with action bit 1
- take_no_action  out  NUM_IR  one-cycle pulse, one-hot, on command pop with action bit 0

## Operation
- Each strobe passes through SYNC_STAGES flops, then an edge register. A rising edge of the synchronised level produces one event.
- Every flop resets to 0. A strobe that is already high at reset release therefore yields exactly one event.
- uir event: ir_latched <= ir_in.
- e1dr event: jdo <= sr. The entry {ir, sr} is pushed to the queue. ir is ir_latched, or ir_in if a uir event occurs in the same cycle.
- Action bit of an entry = sr[SR_WIDTH-1].
- Pop occurs when cmd_valid && cmd_ready. On pop:
  - Next cycle, take_action[cmd_ir] = action bit and take_no_action[cmd_ir] = ~action bit.
  - All other bits are 0.
  - Exactly one bit across both vectors pulses per pop.
- cmd_ready while the queue is empty has no effect.
- Queue full with a push and no pop in the same cycle: the entry is dropped and cmd_overflow is set. jdo still updates.
- Queue full with push and pop in the same cycle: both are accepted and the count is unchanged.
- Queue empty with a push: cmd_valid rises the next cycle. There is no fall-through.
- Pointers wrap modulo FIFO_DEPTH. cmd_count ranges 0..FIFO_DEPTH.
- clr_overflow clears cmd_overflow. An overflow in the same cycle wins, so the flag stays 1.

## Timing
- Reset values (asynchronous): cmd_valid 0, cmd_count 0, cmd_overflow 0, ir_latched 0, jdo 0, take_action 0, take_no_action 0, pointers 0.
- The contents of cmd_ir and cmd_jdo are don't-care while cmd_valid = 0.
- Strobe rising edge at the clk domain to event: SYNC_STAGES+1 clk edges. Example with SYNC_STAGES=2: vs_e1dr is high before edge 0; the event occurs at edge 2; jdo and cmd_valid update at edge 3.
- Pop at edge N: the pulse is high from edge N+1 to edge N+2. cmd_valid, cmd_count and the head update at edge N+1.
- Back-to-back pops with cmd_ready held high: one command per cycle and one pulse per cycle.
- Reset asserted mid-operation: the queue empties immediately, and any pulse in flight is cleared.
- The required minimum strobe high and low time is SYNC_STAGES+1 clk periods. Shorter strobes may be missed.

## Test plan
- Reset: assert reset_n=0 mid-queue with 3 entries -> cmd_valid=0, cmd_count=0, all pulses 0 asynchronously.
- Latency, SYNC_STAGES=2:
  - Stimulus: vs_uir pulse with ir_in=2'b10, then a vs_e1dr pulse with sr=38'h20_0000_0055.
  - Required: cmd_valid at event+1; cmd_ir=2; cmd_jdo=38'h20_0000_0055; cmd_count=1.
  - Required: cmd_ready=1 gives take_action=4'b0100 for one cycle.
- Action bit low: sr[37]=0, ir=1, pop -> take_no_action=4'b0010, take_action=0.
- Overflow, FIFO_DEPTH=4, cmd_ready=0:
  - Stimulus: 5 e1dr events.
  - Required: cmd_count=4, cmd_overflow=1, jdo = the 5th sr.
  - Required: draining yields entries 1-4 in order.
  - Required: clr_overflow clears the flag.
- Full with simultaneous push and pop -> count stays 4, the new entry is the last popped, and cmd_overflow stays 0.
- Parameter sweep: IR_WIDTH=3, SR_WIDTH=64, SYNC_STAGES=3 -> latency 4 cycles, and one-hot pulses on an 8-bit vector.

Source files
------------

// File: rtl/debug_slave_sysclk_queue.sv
// -----------------------------------------------------------------------------
// debug_slave_sysclk_queue
//
// System-clock side of the CPU JTAG debug slave. The update-IR and exit1-DR
// levels from the TCK domain are synchronised and edge-detected. Each update-IR
// event latches the instruction register. Each exit1-DR event snapshots the DR
// shift register into jdo and queues an {ir, sr} command. The head command is
// offered to the debug core over a valid/ready handshake. Every pop produces a
// one-cycle, one-hot take_action / take_no_action pulse that is indexed by the
// command's IR code and selected by the command's action bit (sr MSB).
//
// Parameters:
//   SR_WIDTH     DR snapshot width (jdo / cmd_jdo)
//   IR_WIDTH     instruction width; NUM_IR = 2**IR_WIDTH pulse channels
//   SYNC_STAGES  synchroniser depth per strobe (>= 2)
//   FIFO_DEPTH   command queue depth (power of two, >= 2)
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   vs_uir, vs_e1dr   TCK-domain update-IR / exit1-DR levels (asynchronous)
//   ir_in, sr         instruction and DR shift register from the TCK domain
//   cmd_ready         core accepts the head command
//   clr_overflow      clears the sticky overflow flag
//   cmd_valid         queue is non-empty
//   cmd_ir, cmd_jdo   head command (don't-care while cmd_valid = 0)
//   cmd_count         queue occupancy, 0..FIFO_DEPTH
//   cmd_overflow      sticky: a capture was dropped because the queue was full
//   ir_latched        IR captured at the last update-IR event
//   jdo               sr captured at the last exit1-DR event
//   take_action       one-hot pulse on a pop whose action bit is 1
//   take_no_action    one-hot pulse on a pop whose action bit is 0
// -----------------------------------------------------------------------------
module debug_slave_sysclk_queue #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NUM_IR     = 2 ** IR_WIDTH,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vs_uir,
    input  logic                vs_e1dr,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [SR_WIDTH-1:0] sr,
    input  logic                cmd_ready,
    input  logic                clr_overflow,
    output logic                cmd_valid,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic [SR_WIDTH-1:0] cmd_jdo,
    output logic [CNT_W-1:0]    cmd_count,
    output logic                cmd_overflow,
    output logic [IR_WIDTH-1:0] ir_latched,
    output logic [SR_WIDTH-1:0] jdo,
    output logic [NUM_IR-1:0]   take_action,
    output logic [NUM_IR-1:0]   take_no_action
);

    // Strobe synchronisers, edge registers and registered event pulses
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] e1dr_sync_q;
    logic                   uir_edge_q;
    logic                   e1dr_edge_q;
    logic                   uir_evt_q;
    logic                   e1dr_evt_q;

    // Captured registers
    logic [IR_WIDTH-1:0]    ir_latched_q, ir_latched_d;
    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;

    // Command queue
    logic [IR_WIDTH-1:0]    mem_ir_q  [FIFO_DEPTH];
    logic [SR_WIDTH-1:0]    mem_jdo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;

    // Pop pulses
    logic [NUM_IR-1:0]      take_action_q, take_action_d;
    logic [NUM_IR-1:0]      take_no_action_q, take_no_action_d;

    // Control decode
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   drop;
    logic [IR_WIDTH-1:0]    push_ir;

    // The event is registered, so it lands SYNC_STAGES+1 edges after the
    // strobe is first seen. A strobe already high at reset release still
    // produces one event because the edge register resets to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q  <= '0;
            e1dr_sync_q <= '0;
            uir_edge_q  <= 1'b0;
            e1dr_edge_q <= 1'b0;
            uir_evt_q   <= 1'b0;
            e1dr_evt_q  <= 1'b0;
        end else begin
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            e1dr_sync_q <= {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr};
            uir_edge_q  <= uir_sync_q[SYNC_STAGES-1];
            e1dr_edge_q <= e1dr_sync_q[SYNC_STAGES-1];
            uir_evt_q   <= uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
            e1dr_evt_q  <= e1dr_sync_q[SYNC_STAGES-1] & ~e1dr_edge_q;
        end
    end

    assign cmd_valid = (count_q != '0);
    assign cmd_ir    = mem_ir_q[rd_ptr_q];
    assign cmd_jdo   = mem_jdo_q[rd_ptr_q];

    always_comb begin
        pop     = cmd_valid & cmd_ready;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        // A full queue can still take a push when the head leaves in the same cycle.
        push_ok = e1dr_evt_q & (~full | pop);
        drop    = e1dr_evt_q & full & ~pop;
        // An IR update coinciding with the DR capture applies to that capture.
        push_ir = uir_evt_q ? ir_in : ir_latched_q;

        ir_latched_d = uir_evt_q ? ir_in : ir_latched_q;
        jdo_d        = e1dr_evt_q ? sr : jdo_q;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            if (cmd_jdo[SR_WIDTH-1]) begin
                take_action_d[cmd_ir] = 1'b1;
            end else begin
                take_no_action_d[cmd_ir] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_latched_q     <= '0;
            jdo_q            <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ir_q[i]  <= '0;
                mem_jdo_q[i] <= '0;
            end
        end else begin
            ir_latched_q     <= ir_latched_d;
            jdo_q            <= jdo_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            if (push_ok) begin
                mem_ir_q[wr_ptr_q]  <= push_ir;
                mem_jdo_q[wr_ptr_q] <= sr;
            end
        end
    end

    assign cmd_count      = count_q;
    assign cmd_overflow   = overflow_q;
    assign ir_latched     = ir_latched_q;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;

endmodule

// File: tb/tb_debug_slave_sysclk_queue.sv
// -----------------------------------------------------------------------------
// tb_debug_slave_sysclk_queue
//
// Bench for debug_slave_sysclk_queue. Instance u_dut0 uses default parameters;
// u_dut1 uses IR_WIDTH=3, SR_WIDTH=64, SYNC_STAGES=3. A scoreboard queue holds
// the commands expected from u_dut0 in push order.
// -----------------------------------------------------------------------------
module tb_debug_slave_sysclk_queue;

    localparam int SR0 = 38;
    localparam int IR0 = 2;
    localparam int SS0 = 2;
    localparam int D0  = 4;
    localparam int SR1 = 64;
    localparam int IR1 = 3;
    localparam int SS1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic            vs_uir0, vs_e1dr0, cmd_ready0, clr0;
    logic [IR0-1:0]  ir_in0;
    logic [SR0-1:0]  sr0;
    logic            cmd_valid0, cmd_overflow0;
    logic [IR0-1:0]  cmd_ir0, ir_latched0;
    logic [SR0-1:0]  cmd_jdo0, jdo0;
    logic [2:0]      cmd_count0;
    logic [3:0]      ta0, tna0;

    logic            vs_uir1, vs_e1dr1, cmd_ready1, clr1;
    logic [IR1-1:0]  ir_in1;
    logic [SR1-1:0]  sr1;
    logic            cmd_valid1, cmd_overflow1;
    logic [IR1-1:0]  cmd_ir1, ir_latched1;
    logic [SR1-1:0]  cmd_jdo1, jdo1;
    logic [2:0]      cmd_count1;
    logic [7:0]      ta1, tna1;

    debug_slave_sysclk_queue u_dut0 (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir0), .vs_e1dr(vs_e1dr0),
        .ir_in(ir_in0), .sr(sr0), .cmd_ready(cmd_ready0), .clr_overflow(clr0),
        .cmd_valid(cmd_valid0), .cmd_ir(cmd_ir0), .cmd_jdo(cmd_jdo0),
        .cmd_count(cmd_count0), .cmd_overflow(cmd_overflow0),
        .ir_latched(ir_latched0), .jdo(jdo0),
        .take_action(ta0), .take_no_action(tna0)
    );

    debug_slave_sysclk_queue #(
        .SR_WIDTH(SR1), .IR_WIDTH(IR1), .SYNC_STAGES(SS1), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir1), .vs_e1dr(vs_e1dr1),
        .ir_in(ir_in1), .sr(sr1), .cmd_ready(cmd_ready1), .clr_overflow(clr1),
        .cmd_valid(cmd_valid1), .cmd_ir(cmd_ir1), .cmd_jdo(cmd_jdo1),
        .cmd_count(cmd_count1), .cmd_overflow(cmd_overflow1),
        .ir_latched(ir_latched1), .jdo(jdo1),
        .take_action(ta1), .take_no_action(tna1)
    );

    typedef struct {
        logic [IR0-1:0] ir;
        logic [SR0-1:0] jdo;
    } ent0_t;

    typedef struct {
        logic [IR0-1:0] ir;
        logic [SR0-1:0] sr;
        logic [3:0]     exp_ta;
        logic [3:0]     exp_tna;
    } vec0_t;

    typedef struct {
        logic [IR1-1:0] ir;
        logic [SR1-1:0] sr;
        logic [7:0]     exp_ta;
        logic [7:0]     exp_tna;
    } vec1_t;

    ent0_t          sb0[$];
    logic [IR0-1:0] model_ir0;
    int             errors = 0;
    int             checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] oh0(input logic [IR0-1:0] ir);
        oh0 = 4'b0001 << ir;
    endfunction

    task automatic uir0(input logic [IR0-1:0] ir);
        @(negedge clk);
        ir_in0  = ir;
        vs_uir0 = 1'b1;
        repeat (SS0 + 2) @(negedge clk);
        vs_uir0 = 1'b0;
        repeat (SS0 + 2) @(negedge clk);
        model_ir0 = ir;
    endtask

    // Drives one exit1-DR strobe and records the expected queue entry.
    // With check_lat set the queue must be empty beforehand.
    task automatic e1dr0(input logic [SR0-1:0] s, input bit check_lat);
        @(negedge clk);
        sr0      = s;
        vs_e1dr0 = 1'b1;
        if (sb0.size() < D0) sb0.push_back('{ir: model_ir0, jdo: s});
        if (check_lat) begin
            repeat (SS0 + 1) @(posedge clk);
            @(negedge clk);
            chk("lat_before_event", cmd_valid0, 1'b0);
            @(negedge clk);
            chk("lat_valid", cmd_valid0, 1'b1);
            chk("lat_count", cmd_count0, 3'd1);
        end else begin
            repeat (SS0 + 2) @(negedge clk);
        end
        vs_e1dr0 = 1'b0;
        repeat (SS0 + 2) @(negedge clk);
    endtask

    task automatic pop0(input logic [3:0] exp_ta, input logic [3:0] exp_tna);
        int    n;
        ent0_t e;
        n = 0;
        while (!cmd_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_valid0) begin
            chk("pop_wait_valid", 1'b0, 1'b1);
            return;
        end
        if (sb0.size() == 0) begin
            chk("pop_scoreboard_empty", 1'b0, 1'b1);
            return;
        end
        e = sb0.pop_front();
        chk("head_ir", cmd_ir0, e.ir);
        chk("head_jdo", cmd_jdo0, e.jdo);
        cmd_ready0 = 1'b1;
        @(negedge clk);
        cmd_ready0 = 1'b0;
        chk("pulse_ta", ta0, exp_ta);
        chk("pulse_tna", tna0, exp_tna);
        @(negedge clk);
        chk("pulse_end", {ta0, tna0}, 8'h00);
    endtask

    // Pops the head and derives the expected pulse from the scoreboard entry.
    task automatic pop0_auto();
        logic [3:0] a, na;
        a  = 4'b0;
        na = 4'b0;
        if (sb0.size() != 0) begin
            if (sb0[0].jdo[SR0-1]) a = oh0(sb0[0].ir);
            else na = oh0(sb0[0].ir);
        end
        pop0(a, na);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec0_t          vecs0[4];
        vec1_t          vecs1[2];
        logic [SR0-1:0] ovf_sr[5];
        ent0_t          e;

        vecs0[0] = '{ir: 2'd2, sr: 38'h20_0000_0055, exp_ta: 4'b0100, exp_tna: 4'b0000};
        vecs0[1] = '{ir: 2'd1, sr: 38'h0F_1234_5678, exp_ta: 4'b0000, exp_tna: 4'b0010};
        vecs0[2] = '{ir: 2'd0, sr: 38'h3F_FFFF_FFFF, exp_ta: 4'b0001, exp_tna: 4'b0000};
        vecs0[3] = '{ir: 2'd3, sr: 38'h00_0000_0000, exp_ta: 4'b0000, exp_tna: 4'b1000};
        vecs1[0] = '{ir: 3'd5, sr: 64'h8000_0000_0000_1234, exp_ta: 8'h20, exp_tna: 8'h00};
        vecs1[1] = '{ir: 3'd6, sr: 64'h7FFF_0000_ABCD_0001, exp_ta: 8'h00, exp_tna: 8'h40};
        ovf_sr[0] = 38'h21_1111_1111;
        ovf_sr[1] = 38'h02_2222_2222;
        ovf_sr[2] = 38'h23_3333_3333;
        ovf_sr[3] = 38'h04_4444_4444;
        ovf_sr[4] = 38'h25_5555_5555;

        reset_n = 1'b0;
        vs_uir0 = 0; vs_e1dr0 = 0; cmd_ready0 = 0; clr0 = 0; ir_in0 = '0; sr0 = '0;
        vs_uir1 = 0; vs_e1dr1 = 0; cmd_ready1 = 0; clr1 = 0; ir_in1 = '0; sr1 = '0;
        model_ir0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", cmd_valid0, 1'b0);
        chk("rst_count", cmd_count0, 3'd0);
        chk("rst_overflow", cmd_overflow0, 1'b0);
        chk("rst_pulses", {ta0, tna0}, 8'h00);
        chk("rst_jdo", jdo0, '0);
        chk("rst_ir_latched", ir_latched0, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single command path
        for (int i = 0; i < 4; i++) begin
            uir0(vecs0[i].ir);
            chk("ir_latched", ir_latched0, vecs0[i].ir);
            e1dr0(vecs0[i].sr, 1'b1);
            chk("jdo", jdo0, vecs0[i].sr);
            pop0(vecs0[i].exp_ta, vecs0[i].exp_tna);
            chk("empty_after_pop", cmd_count0, 3'd0);
        end

        // Overflow: five captures into a depth-4 queue with the core stalled
        for (int i = 0; i < 5; i++) e1dr0(ovf_sr[i], 1'b0);
        chk("ovf_count", cmd_count0, 3'd4);
        chk("ovf_flag", cmd_overflow0, 1'b1);
        chk("ovf_jdo_last", jdo0, ovf_sr[4]);
        for (int i = 0; i < 4; i++) pop0_auto();
        chk("ovf_drained", cmd_valid0, 1'b0);
        chk("ovf_sticky", cmd_overflow0, 1'b1);
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("ovf_cleared", cmd_overflow0, 1'b0);

        // Full queue with push and pop landing in the same cycle
        for (int i = 0; i < 4; i++) e1dr0(ovf_sr[i], 1'b0);
        chk("full_count", cmd_count0, 3'd4);
        @(negedge clk);
        sr0      = 38'h3A_BCDE_F012;
        vs_e1dr0 = 1'b1;
        repeat (SS0 + 1) @(posedge clk);
        @(negedge clk);
        e = sb0.pop_front();
        chk("sim_head_jdo", cmd_jdo0, e.jdo);
        sb0.push_back('{ir: model_ir0, jdo: 38'h3A_BCDE_F012});
        cmd_ready0 = 1'b1;
        @(negedge clk);
        cmd_ready0 = 1'b0;
        chk("sim_count", cmd_count0, 3'd4);
        chk("sim_no_overflow", cmd_overflow0, 1'b0);
        chk("sim_pulse", e.jdo[SR0-1] ? ta0 : tna0, oh0(e.ir));
        vs_e1dr0 = 1'b0;
        repeat (SS0 + 2) @(negedge clk);
        for (int i = 0; i < 4; i++) pop0_auto();
        chk("sim_drained", cmd_valid0, 1'b0);

        // Asynchronous reset with three queued entries and a pulse in flight
        for (int i = 0; i < 3; i++) e1dr0(ovf_sr[i], 1'b0);
        chk("pre_rst_count", cmd_count0, 3'd3);
        @(negedge clk);
        cmd_ready0 = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_pulse", ((ta0 | tna0) != 4'b0), 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", cmd_valid0, 1'b0);
        chk("arst_count", cmd_count0, 3'd0);
        chk("arst_pulses", {ta0, tna0}, 8'h00);
        chk("arst_jdo", jdo0, '0);
        sb0.delete();
        model_ir0 = '0;
        @(negedge clk);
        cmd_ready0 = 1'b0;
        reset_n    = 1'b1;
        repeat (2) @(negedge clk);

        // Wider instance: SYNC_STAGES=3, 8 pulse channels
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ir_in1  = vecs1[i].ir;
            vs_uir1 = 1'b1;
            repeat (SS1 + 2) @(negedge clk);
            vs_uir1 = 1'b0;
            repeat (SS1 + 2) @(negedge clk);
            chk("w_ir_latched", ir_latched1, vecs1[i].ir);
            sr1      = vecs1[i].sr;
            vs_e1dr1 = 1'b1;
            repeat (SS1 + 1) @(posedge clk);
            @(negedge clk);
            chk("w_lat_before_event", cmd_valid1, 1'b0);
            @(negedge clk);
            chk("w_lat_valid", cmd_valid1, 1'b1);
            chk("w_head_ir", cmd_ir1, vecs1[i].ir);
            chk("w_head_jdo", cmd_jdo1, vecs1[i].sr);
            vs_e1dr1 = 1'b0;
            repeat (SS1 + 2) @(negedge clk);
            cmd_ready1 = 1'b1;
            @(negedge clk);
            cmd_ready1 = 1'b0;
            chk("w_pulse_ta", ta1, vecs1[i].exp_ta);
            chk("w_pulse_tna", tna1, vecs1[i].exp_tna);
            @(negedge clk);
            chk("w_pulse_end", {ta1, tna1}, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
